// File: rtl/mpx_stat.sv
// Signed min/max/count statistics over a programmable window of valid MPX samples.
// One-shot or continuous windows; stat_limit == 0 selects live (never-closing) mode.
module mpx_stat #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [1:0]        stat_cfg,
  input  logic [CNT_W-1:0]  stat_limit,
  output logic [DATA_W-1:0] stat_min,
  output logic [DATA_W-1:0] stat_max,
  output logic [CNT_W-1:0]  stat_count,
  output logic              stat_done,
  output logic              stat_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  localparam logic [CNT_W:0] CntOne = 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   run_min_q, run_min_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   stat_min_q, stat_min_d;
  logic [DATA_W-1:0]   stat_max_q, stat_max_d;
  logic [CNT_W-1:0]    stat_count_q, stat_count_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   samp_min, samp_max;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W:0]      cnt_sum;
  logic                win_close;

  // Running extremes including the current sample; the first sample seeds both.
  always_comb begin
    samp_min = first_q ? in_data :
               ($signed(in_data) < $signed(run_min_q)) ? in_data : run_min_q;
    samp_max = first_q ? in_data :
               ($signed(in_data) > $signed(run_max_q)) ? in_data : run_max_q;
    cnt_inc  = (run_cnt_q == {CNT_W{1'b1}}) ? run_cnt_q : run_cnt_q + 1'b1;
    // Widened sum so the close compare cannot wrap at a saturated counter.
    cnt_sum   = {1'b0, run_cnt_q} + CntOne;
    win_close = (stat_limit != '0) && (cnt_sum >= {1'b0, stat_limit});
  end

  always_comb begin
    state_d      = state_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    run_cnt_d    = run_cnt_q;
    first_d      = first_q;
    stat_min_d   = stat_min_q;
    stat_max_d   = stat_max_q;
    stat_count_d = stat_count_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        run_min_d = '0;
        run_max_d = '0;
        run_cnt_d = '0;
        first_d   = 1'b1;
        if (stat_cfg[0]) state_d = StRun;
      end
      StRun: begin
        if (!stat_cfg[0]) begin
          state_d = StIdle;
        end else if (in_valid) begin
          if (win_close) begin
            stat_min_d   = samp_min;
            stat_max_d   = samp_max;
            stat_count_d = cnt_inc;
            done_d       = 1'b1;
            run_min_d    = '0;
            run_max_d    = '0;
            run_cnt_d    = '0;
            first_d      = 1'b1;
            state_d      = stat_cfg[1] ? StRun : StHold;
          end else begin
            run_min_d = samp_min;
            run_max_d = samp_max;
            run_cnt_d = cnt_inc;
            first_d   = 1'b0;
            if (stat_limit == '0) begin
              stat_min_d   = samp_min;
              stat_max_d   = samp_max;
              stat_count_d = cnt_inc;
            end
          end
        end
      end
      StHold: begin
        if (!stat_cfg[0]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      run_min_q    <= '0;
      run_max_q    <= '0;
      run_cnt_q    <= '0;
      first_q      <= 1'b1;
      stat_min_q   <= '0;
      stat_max_q   <= '0;
      stat_count_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      run_cnt_q    <= run_cnt_d;
      first_q      <= first_d;
      stat_min_q   <= stat_min_d;
      stat_max_q   <= stat_max_d;
      stat_count_q <= stat_count_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign stat_min   = stat_min_q;
  assign stat_max   = stat_max_q;
  assign stat_count = stat_count_q;
  assign stat_done  = done_q;
  assign stat_busy  = busy_q;

endmodule

// File: tb/tb_mpx_stat.sv
// Directed bench for mpx_stat: one-shot, continuous, live, gaps, abort/re-arm, async reset.
module tb_mpx_stat;

  logic        clk;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [1:0]  stat_cfg;
  logic [31:0] stat_limit;
  logic [7:0]  stat_min;
  logic [7:0]  stat_max;
  logic [31:0] stat_count;
  logic        stat_done;
  logic        stat_busy;

  int checks = 0;
  int errors = 0;

  mpx_stat #(.DATA_W(8), .CNT_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .stat_cfg  (stat_cfg),
    .stat_limit(stat_limit),
    .stat_min  (stat_min),
    .stat_max  (stat_max),
    .stat_count(stat_count),
    .stat_done (stat_done),
    .stat_busy (stat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] mn, input logic [7:0] mx,
                           input logic [31:0] cnt);
    check({tag, ".min"}, 32'(stat_min), 32'(mn));
    check({tag, ".max"}, 32'(stat_max), 32'(mx));
    check({tag, ".count"}, stat_count, cnt);
  endtask

  initial begin
    resetn     = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    stat_cfg   = 2'b00;
    stat_limit = '0;
    #12;
    check_out("reset", 8'h00, 8'h00, 32'd0);
    check("reset.done", 32'(stat_done), 32'd0);
    check("reset.busy", 32'(stat_busy), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: one-shot window of 4
    stat_limit = 32'd4;
    stat_cfg   = 2'b01;
    tick();
    check("t1.busy_run", 32'(stat_busy), 32'd1);
    sample(8'd5);
    sample(8'hFD);
    sample(8'd10);
    check("t1.no_early_done", 32'(stat_done), 32'd0);
    sample(8'd2);
    check_out("t1", 8'hFD, 8'h0A, 32'd4);
    check("t1.done", 32'(stat_done), 32'd1);
    check("t1.busy_hold", 32'(stat_busy), 32'd0);
    tick();
    check("t1.done_one_cycle", 32'(stat_done), 32'd0);
    sample(8'd100);
    sample(8'h9C);
    check_out("t1.hold", 8'hFD, 8'h0A, 32'd4);
    check("t1.hold_done", 32'(stat_done), 32'd0);

    // 5: abort and re-arm
    stat_cfg = 2'b00;
    tick();
    stat_cfg = 2'b01;
    tick();
    sample(8'd50);
    sample(8'hCE);
    stat_cfg = 2'b00;
    tick();
    check("t5.abort_done", 32'(stat_done), 32'd0);
    check("t5.abort_busy", 32'(stat_busy), 32'd0);
    check_out("t5.abort", 8'hFD, 8'h0A, 32'd4);
    stat_cfg = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) sample(8'd9);
    check_out("t5.rearm", 8'd9, 8'd9, 32'd4);
    check("t5.rearm_done", 32'(stat_done), 32'd1);
    stat_cfg = 2'b00;
    tick();

    // 2: continuous, back-to-back windows of 2
    stat_limit = 32'd2;
    stat_cfg   = 2'b11;
    tick();
    sample(8'd1);
    in_valid = 1'b1; in_data = 8'd2; tick();
    check_out("t2.w1", 8'd1, 8'd2, 32'd2);
    check("t2.w1_done", 32'(stat_done), 32'd1);
    check("t2.w1_busy", 32'(stat_busy), 32'd1);
    in_data = 8'hFF; tick();
    check("t2.mid_done", 32'(stat_done), 32'd0);
    in_data = 8'hFB; tick();
    in_valid = 1'b0;
    check_out("t2.w2", 8'hFB, 8'hFF, 32'd2);
    check("t2.w2_done", 32'(stat_done), 32'd1);
    check("t2.w2_busy", 32'(stat_busy), 32'd1);
    stat_cfg = 2'b00;
    tick();

    // 3: live mode with extremes
    stat_limit = 32'd0;
    stat_cfg   = 2'b01;
    tick();
    sample(8'd7);
    check_out("t3.s1", 8'd7, 8'd7, 32'd1);
    check("t3.s1_done", 32'(stat_done), 32'd0);
    sample(8'h80);
    check_out("t3.s2", 8'h80, 8'd7, 32'd2);
    check("t3.s2_done", 32'(stat_done), 32'd0);
    sample(8'h7F);
    check_out("t3.s3", 8'h80, 8'h7F, 32'd3);
    check("t3.s3_done", 32'(stat_done), 32'd0);
    stat_cfg = 2'b00;
    tick();

    // 4: valid gaps, one sample every third cycle
    stat_limit = 32'd3;
    stat_cfg   = 2'b01;
    tick();
    tick(); tick(); sample(8'd4);
    tick(); tick(); sample(8'd6);
    check("t4.no_early_done", 32'(stat_done), 32'd0);
    tick(); tick(); sample(8'd5);
    check_out("t4", 8'd4, 8'd6, 32'd3);
    check("t4.done", 32'(stat_done), 32'd1);
    stat_cfg = 2'b00;
    tick();

    // 6: async reset mid-window, then fresh window seeded by its first sample
    stat_limit = 32'd4;
    stat_cfg   = 2'b01;
    tick();
    sample(8'd3);
    sample(8'd8);
    #2;
    resetn = 1'b0;
    #1;
    check_out("t6.reset", 8'h00, 8'h00, 32'd0);
    check("t6.reset_busy", 32'(stat_busy), 32'd0);
    #1;
    resetn = 1'b1;
    tick();
    check("t6.rearm_busy", 32'(stat_busy), 32'd1);
    sample(8'hFE);
    sample(8'hF9);
    sample(8'hFD);
    sample(8'hFC);
    check_out("t6.fresh", 8'hF9, 8'hFE, 32'd4);
    check("t6.done", 32'(stat_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
